// File: rtl/i2s_rx_axis.sv
`default_nettype none
// ============================================================================
// Module   : i2s_rx_axis
// Purpose  : I2S master receiver. Generates BCLK/LRCLK from aclk, deserialises
//            SAMPLE_W-bit stereo audio (MSB first, one-bit I2S delay) and packs
//            each {left,right} pair into one 32-bit AXI-Stream word. tlast marks
//            every FRAME_LEN-th pushed word. A first-word-fall-through FIFO
//            absorbs downstream backpressure; words arriving while it is full
//            are dropped and a sticky overflow flag is raised.
// Ports    : aclk, aresetn (async, active low)
//            enable                 - run (1) / idle (0) the I2S interface
//            i2s_bclk, i2s_lrclk    - bit clock / word select (0 = left)
//            i2s_sdata              - serial data from codec
//            m_axis_tdata/tvalid/tready/tlast - AXI-Stream master
//            overflow, overflow_clr - sticky drop flag and its clear pulse
//            fifo_level             - current FIFO occupancy
// Revision : 1.0 - initial release
// ============================================================================
module i2s_rx_axis #(
   parameter int CLK_DIV    = 4,
   parameter int SAMPLE_W   = 16,
   parameter int FRAME_LEN  = 1024,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                          aclk,
   input  logic                          aresetn,
   input  logic                          enable,
   output logic                          i2s_bclk,
   output logic                          i2s_lrclk,
   input  logic                          i2s_sdata,
   output logic [31:0]                   m_axis_tdata,
   output logic                          m_axis_tvalid,
   input  logic                          m_axis_tready,
   output logic                          m_axis_tlast,
   output logic                          overflow,
   input  logic                          overflow_clr,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

   localparam int C_HALF = CLK_DIV / 2;
   localparam int C_DW   = $clog2(CLK_DIV);
   localparam int C_AW   = $clog2(FIFO_DEPTH);
   localparam int C_LW   = C_AW + 1;
   localparam int C_WW   = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

   // ------------------------------------------------------------------------
   // Clock generation
   // ------------------------------------------------------------------------
   logic [C_DW-1:0] r_div;
   logic [C_DW-1:0] w_div_nxt;
   logic [5:0]      r_bit;
   logic            r_bclk;
   logic            w_rise;
   logic            w_fall;

   always_comb begin
      w_div_nxt = (r_div == C_DW'(CLK_DIV - 1)) ? '0 : r_div + 1'b1;
      // The rising edge is the cycle in which the divider enters its upper half;
      // sdata is sampled on that same aclk edge.
      w_rise    = enable && (w_div_nxt == C_DW'(C_HALF));
      // The falling edge coincides with the divider wrapping to zero.
      w_fall    = enable && (r_div == C_DW'(CLK_DIV - 1));
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_div  <= '0;
         r_bclk <= 1'b0;
         r_bit  <= '0;
      end else if (!enable) begin
         r_div  <= '0;
         r_bclk <= 1'b0;
         r_bit  <= '0;
      end else begin
         r_div  <= w_div_nxt;
         r_bclk <= (w_div_nxt >= C_DW'(C_HALF));
         if (w_fall)
            r_bit <= r_bit + 6'd1;
      end
   end

   assign i2s_bclk  = r_bclk;
   assign i2s_lrclk = r_bit[5];

   // ------------------------------------------------------------------------
   // Capture: slot position 0 is the I2S delay bit, 1..SAMPLE_W carry MSB..LSB
   // ------------------------------------------------------------------------
   logic [4:0]          w_pos;
   logic                w_slot;
   logic                w_in_sample;
   logic [SAMPLE_W-1:0] r_sh_l;
   logic [SAMPLE_W-1:0] r_sh_r;
   logic [SAMPLE_W-1:0] w_sh_l_nxt;
   logic [SAMPLE_W-1:0] w_sh_r_nxt;
   logic                w_push;
   logic [31:0]         w_push_data;

   always_comb begin
      w_pos       = r_bit[4:0];
      w_slot      = r_bit[5];
      w_in_sample = (w_pos != 5'd0) && (w_pos <= 5'(SAMPLE_W));
      w_sh_l_nxt  = SAMPLE_W'({r_sh_l, i2s_sdata});
      w_sh_r_nxt  = SAMPLE_W'({r_sh_r, i2s_sdata});
      // The pair is complete as the right LSB arrives, so push it from the
      // shift-in value rather than waiting a cycle for the register.
      w_push      = w_rise && w_slot && (w_pos == 5'(SAMPLE_W));
      w_push_data = 32'({r_sh_l, w_sh_r_nxt});
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_sh_l <= '0;
         r_sh_r <= '0;
      end else if (!enable) begin
         r_sh_l <= '0;
         r_sh_r <= '0;
      end else if (w_rise && w_in_sample) begin
         if (w_slot)
            r_sh_r <= w_sh_r_nxt;
         else
            r_sh_l <= w_sh_l_nxt;
      end
   end

   // ------------------------------------------------------------------------
   // Packet counter and output FIFO
   // ------------------------------------------------------------------------
   logic [C_WW-1:0] r_word;
   logic            w_last;
   logic [32:0]     r_mem [FIFO_DEPTH];
   logic [C_AW-1:0] r_wp;
   logic [C_AW-1:0] r_rp;
   logic [C_LW-1:0] r_count;
   logic            w_full;
   logic            w_valid;
   logic            w_pop;
   logic            w_wr_en;
   logic            w_drop;
   logic [32:0]     w_rd;
   logic            r_ovf;

   always_comb begin
      w_last  = (r_word == C_WW'(FRAME_LEN - 1));
      w_full  = (r_count == C_LW'(FIFO_DEPTH));
      w_valid = (r_count != '0);
      w_pop   = w_valid && m_axis_tready;
      // A pop in the same cycle frees the slot, so a full FIFO still accepts.
      w_wr_en = w_push && (!w_full || w_pop);
      w_drop  = w_push && w_full && !w_pop;
      w_rd    = r_mem[r_rp];
   end

   always_ff @(posedge aclk) begin
      if (w_wr_en)
         r_mem[r_wp] <= {w_last, w_push_data};
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_wp    <= '0;
         r_rp    <= '0;
         r_count <= '0;
         r_word  <= '0;
         r_ovf   <= 1'b0;
      end else begin
         if (w_wr_en) begin
            r_wp   <= r_wp + 1'b1;
            r_word <= w_last ? '0 : r_word + 1'b1;
         end
         if (w_pop)
            r_rp <= r_rp + 1'b1;
         case ({w_wr_en, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
         // A fresh drop wins over a simultaneous clear.
         if (w_drop)
            r_ovf <= 1'b1;
         else if (overflow_clr)
            r_ovf <= 1'b0;
      end
   end

   // Memory is not reset; gating with valid keeps tdata/tlast at 0 when empty.
   assign m_axis_tvalid = w_valid;
   assign m_axis_tdata  = w_valid ? w_rd[31:0] : 32'd0;
   assign m_axis_tlast  = w_valid && w_rd[32];
   assign overflow      = r_ovf;
   assign fifo_level    = r_count;

endmodule
`default_nettype wire
